loopback_engine: RTL
====================

LOOPBACK_ENGINE -- requirements
Module: loopback_engine

Parameters
REQ-001 SHALL provide DATA_WIDTH, default 512: width of the read-response and write-request data.
REQ-002 SHALL provide FIFO_DEPTH, default 512, power of two, minimum 4: number of entries in the internal buffer.
REQ-003 SHALL provide LEN_WIDTH, default 16: width of the transfer-length and count fields.

Interface
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start  in  1  level; a transfer begins on a rising detection while in IDLE.
REQ-007 len  in  LEN_WIDTH  number of lines to copy; sampled with start.
REQ-008 mode  in  2  data transform; sampled with start.
REQ-009 rd_req_valid  out  1  one read request per asserted cycle.
REQ-010 rd_req_full  in  1  host back-pressure; no read request SHALL be issued while it is high.
REQ-011 rd_rsp_valid  in  1  one response line per asserted cycle, in order.
REQ-012 rd_rsp_data  in  DATA_WIDTH  response data.
REQ-013 wr_req_valid  out  1  one write request per asserted cycle.
REQ-014 wr_req_data  out  DATA_WIDTH  transformed write data.
REQ-015 wr_req_full  in  1  host back-pressure; no write request SHALL be issued while it is high.
REQ-016 busy  out  1  high in RUN.
REQ-017 finish  out  1  high in DONE.
REQ-018 err  out  1  sticky unexpected-response flag.
REQ-019 wr_count  out  LEN_WIDTH  writes issued in the current transfer.

Function
REQ-020 States SHALL be IDLE, RUN and DONE.
- IDLE->RUN: start=1 and len!=0.
- IDLE->DONE: start=1 and len=0, with no read or write issued.
- RUN->DONE: in the cycle after the len-th write issues.
- DONE->IDLE: when start=0.
REQ-021 start SHALL be ignored in RUN; len and mode SHALL be held internally from IDLE exit.
REQ-022 On IDLE exit, err and wr_count SHALL clear; the read-issued, credit and FIFO counters SHALL also clear.
REQ-023 Read issue condition: rd_req_valid=1 only in RUN, when reads_issued<len, rd_req_full=0, and outstanding+fifo_occupancy<FIFO_DEPTH. The FIFO SHALL never overflow.
REQ-024 Response capture:
- A valid response in RUN with outstanding>0 SHALL be registered and enqueued one cycle later.
- Outstanding SHALL decrement in the response cycle.
- A read issue and a response in the same cycle SHALL leave outstanding unchanged.
REQ-025 An unexpected response (any state, outstanding=0) SHALL be dropped, not enqueued, and SHALL set err.
REQ-026 Dequeue SHALL occur when the FIFO is non-empty and wr_req_full=0. The write SHALL be presented registered in the following cycle: wr_req_valid=1, wr_req_data=f(data).
REQ-027 Latency: response at cycle t with wr_req_full low and FIFO empty -> wr_req_valid at t+3.
REQ-028 Enqueue and dequeue in the same cycle SHALL be supported, leaving occupancy unchanged, including at full and at one-entry occupancy.
REQ-029 mode SHALL select the transform:
- 0: pass-through.
- 1: bitwise invert.
- 2: byte-order reverse (byte 0 <-> byte DATA_WIDTH/8-1).
- 3: pass-through.
REQ-030 wr_count SHALL increment by one per issued write and SHALL stop at len.
REQ-031 Counter comparisons SHALL be unsigned at LEN_WIDTH; counters SHALL not wrap because len <= 2^LEN_WIDTH-1.
REQ-032 Write order SHALL equal response order.

Reset
REQ-033 On reset the block SHALL be in IDLE with FIFO empty and all counters zero.
REQ-034 On reset rd_req_valid, wr_req_valid, busy, finish and err SHALL be 0; wr_count, wr_req_data and the internal data registers SHALL be 0.
REQ-035 Reset mid-RUN SHALL abort immediately and discard FIFO contents. Responses arriving after reset SHALL set err.

Verification
REQ-036 len=4, mode=0, no back-pressure, responses returned 2 cycles after each request with data 1..4 -> exactly 4 reads and 4 writes with data 1..4; finish=1; wr_count=4.
REQ-037 FIFO_DEPTH=4, len=16, wr_req_full held high for 40 cycles -> reads stall after 4 outstanding/occupied. No overflow; all 16 lines written in order once wr_req_full releases.
REQ-038 mode=1 with data 0x0..0F, then mode=2 with byte0=0xAA -> writes ~data in the first transfer; in the second, byte DATA_WIDTH/8-1 = 0xAA.
REQ-039 len=0 start -> DONE the next cycle; finish=1; no rd_req_valid or wr_req_valid ever asserted.
REQ-040 Response pulse in IDLE -> err=1, nothing written. A subsequent start clears err.
REQ-041 Reset asserted mid-transfer after 3 of 8 writes -> all outputs 0 within the reset cycle. A fresh start with len=2 completes with exactly 2 writes.

Source files
------------

// File: rtl/loopback_engine_if.sv
// Host-facing channels of the loopback engine: command, read request/response,
// write request and status.
interface loopback_engine_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned LEN_WIDTH  = 16
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic [1:0]            mode;
    logic                  rd_req_valid;
    logic                  rd_req_full;
    logic                  rd_rsp_valid;
    logic [DATA_WIDTH-1:0] rd_rsp_data;
    logic                  wr_req_valid;
    logic [DATA_WIDTH-1:0] wr_req_data;
    logic                  wr_req_full;
    logic                  busy;
    logic                  finish;
    logic                  err;
    logic [LEN_WIDTH-1:0]  wr_count;

    // Host side: drives commands, responses and back-pressure.
    modport master (
        output start, len, mode, rd_req_full, rd_rsp_valid, rd_rsp_data, wr_req_full,
        input  rd_req_valid, wr_req_valid, wr_req_data, busy, finish, err, wr_count
    );

    // Engine side.
    modport slave (
        input  start, len, mode, rd_req_full, rd_rsp_valid, rd_rsp_data, wr_req_full,
        output rd_req_valid, wr_req_valid, wr_req_data, busy, finish, err, wr_count
    );
endinterface

// File: rtl/loopback_engine.sv
// Copies len lines from the host read channel to the write channel through a
// credit-guarded FIFO, applying a per-transfer data transform.
module loopback_engine #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input logic              clk,
    input logic              reset,
    loopback_engine_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic                  r_start_prev;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [1:0]            r_mode;
    logic [LEN_WIDTH-1:0]  r_reads;
    logic [CW-1:0]         r_out;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_valid;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [LEN_WIDTH-1:0]  r_wr_count;
    logic                  r_err;

    logic                  w_start_rise;
    logic                  w_launch;
    logic                  w_in_run;
    logic [CW:0]           w_credit;
    logic                  w_credit_ok;
    logic                  w_rd_issue;
    logic                  w_rsp_ok;
    logic                  w_rsp_bad;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_last_wr;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_xform;

    assign w_start_rise = bus.start & ~r_start_prev;
    assign w_launch     = (r_state == StIdle) & w_start_rise;
    assign w_in_run     = (r_state == StRun);

    // The staged response is already committed to a FIFO slot, so it holds a credit too.
    assign w_credit    = {1'b0, r_out} + {1'b0, r_count} + {{CW{1'b0}}, r_rsp_valid};
    assign w_credit_ok = w_credit < (CW + 1)'(FIFO_DEPTH);

    assign w_rd_issue = w_in_run & (r_reads < r_len) & ~bus.rd_req_full & w_credit_ok;
    assign w_rsp_ok   = bus.rd_rsp_valid & w_in_run & (r_out != '0);
    assign w_rsp_bad  = bus.rd_rsp_valid & ~w_rsp_ok;
    assign w_enq      = r_rsp_valid;
    assign w_deq      = (r_count != '0) & ~bus.wr_req_full;
    assign w_last_wr  = r_wr_valid & w_in_run & (r_wr_count == r_len - 1'b1);

    always_comb begin
        w_head  = r_mem[r_rd_ptr];
        w_xform = w_head;
        unique case (r_mode)
            2'd1: w_xform = ~w_head;
            2'd2: begin
                for (int i = 0; i < NB; i++) begin
                    w_xform[8*i +: 8] = w_head[8*(NB-1-i) +: 8];
                end
            end
            default: w_xform = w_head;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start_rise) begin
                    w_state_d = (bus.len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (w_last_wr) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (!bus.start) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy         = (r_state == StRun);
        bus.finish       = (r_state == StDone);
        bus.rd_req_valid = w_rd_issue;
        bus.wr_req_valid = r_wr_valid;
        bus.wr_req_data  = r_wr_data;
        bus.err          = r_err;
        bus.wr_count     = r_wr_count;
    end

    // Command capture and read-side credit tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_prev <= 1'b0;
            r_len        <= '0;
            r_mode       <= '0;
            r_reads      <= '0;
            r_out        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_start_prev <= bus.start;
            if (w_launch) begin
                r_len       <= bus.len;
                r_mode      <= bus.mode;
                r_reads     <= '0;
                r_out       <= '0;
                r_rsp_valid <= 1'b0;
            end else begin
                if (w_rd_issue) begin
                    r_reads <= r_reads + 1'b1;
                end
                unique case ({w_rd_issue, w_rsp_ok})
                    2'b10:   r_out <= r_out + 1'b1;
                    2'b01:   r_out <= r_out - 1'b1;
                    default: r_out <= r_out;
                endcase
                r_rsp_valid <= w_rsp_ok;
                if (w_rsp_ok) begin
                    r_rsp_data <= bus.rd_rsp_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= r_rsp_data;
        end
    end

    // FIFO pointers, registered write output and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
            r_wr_count <= '0;
            r_err      <= 1'b0;
        end else if (w_launch) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_valid <= 1'b0;
            r_wr_count <= '0;
            r_err      <= w_rsp_bad;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_wr_data <= w_xform;
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_wr_valid <= w_deq;
            if (r_wr_valid && (r_wr_count != r_len)) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            if (w_rsp_bad) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule
